// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// 4-bit ripple-carry adder slice; the only adder hardware in the serial datapath.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a shared rca4, carry held in a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int N    = WIDTH / NIB;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;

  logic [IDXW+1:0]  nib_base;
  logic [NIB-1:0]   a_nib, b_nib, rca_s;
  logic             rca_co;

  // Bit offset of the current nibble; widened so idx*4 cannot wrap.
  assign nib_base = {idx_q, 2'b00};
  assign a_nib    = a_q[nib_base +: NIB];
  assign b_nib    = b_q[nib_base +: NIB];

  rca4 U0_rca4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (rca_s),
    .co (rca_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          s_d     = '0;
          co_d    = 1'b0;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        s_d[nib_base +: NIB] = rca_s;
        carry_d              = rca_co;
        idx_d                = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          co_d    = rca_co;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule
